// File: rtl/output_argmax.sv
// rtl/output_argmax.sv - signed argmax scan over one store-bank region
// Walks NUM_CLASSES entries via o_rd_sel, one per cycle, and reports the winning class.
module output_argmax #(
  parameter int DATA_W      = 8,
  parameter int NUM_CLASSES = 10,
  parameter int BASE        = 10,
  parameter int IDX_W       = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [31:0]       o_rd_sel,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [IDX_W-1:0]  o_class_idx,
  output logic [DATA_W-1:0] o_class_val
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [IDX_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_best_idx;
  logic [DATA_W-1:0] r_best_val;
  logic [IDX_W-1:0]  r_class_idx;
  logic [DATA_W-1:0] r_class_val;

  logic              w_last;
  logic              w_take;
  logic [IDX_W-1:0]  w_cand_idx;
  logic [DATA_W-1:0] w_cand_val;

  assign w_last = (r_cnt == IDX_W'(NUM_CLASSES - 1));
  // Entry 0 seeds the running best, so the reset value of best never competes.
  assign w_take     = (r_cnt == '0) || ($signed(i_rd_data) > $signed(r_best_val));
  assign w_cand_idx = w_take ? r_cnt : r_best_idx;
  assign w_cand_val = w_take ? i_rd_data : r_best_val;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next_state = S_SCAN;
      S_SCAN:  if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_best_idx  <= '0;
      r_best_val  <= '0;
      r_class_idx <= '0;
      r_class_val <= '0;
    end else begin
      case (r_state)
        S_SCAN: begin
          r_best_idx <= w_cand_idx;
          r_best_val <= w_cand_val;
          if (w_last) begin
            r_cnt       <= '0;
            r_class_idx <= w_cand_idx;
            r_class_val <= w_cand_val;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_rd_sel    = 32'(BASE) + 32'(r_cnt);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_class_idx = r_class_idx;
  assign o_class_val = r_class_val;

endmodule

// File: tb/tb_output_argmax.sv
// tb/tb_output_argmax.sv - table-driven bench with result scoreboard for output_argmax
// Models the store bank as a combinational lookup over addresses 10..19.
module tb_output_argmax;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] rd_sel;
  logic [7:0]  rd_data;
  logic        busy;
  logic        done;
  logic [3:0]  class_idx;
  logic [7:0]  class_val;

  logic [0:9][7:0] bank;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [0:9][7:0] v;
    logic [3:0]      idx;
    logic [7:0]      val;
  } vec_t;

  vec_t vecs[7];
  logic [11:0] exp_q[$];

  output_argmax dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .o_rd_sel    (rd_sel),
    .i_rd_data   (rd_data),
    .o_busy      (busy),
    .o_done      (done),
    .o_class_idx (class_idx),
    .o_class_val (class_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rd_data = 8'h00;
    if (rd_sel >= 32'd10 && rd_sel <= 32'd19) rd_data = bank[int'(rd_sel) - 10];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done idx=%0d val=%0h", class_idx, class_val);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("sb_class_idx", {28'd0, class_idx}, {28'd0, e[11:8]});
        check("sb_class_val", {24'd0, class_val}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic run_vec(input int i, input bit extra_start);
    bank  = vecs[i].v;
    start = 1'b1;
    exp_q.push_back({vecs[i].idx, vecs[i].val});
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("rd_sel_step", rd_sel, 32'(10 + k));
      check("busy_scan", {31'd0, busy}, 32'd1);
      check("done_low_scan", {31'd0, done}, 32'd0);
      if (extra_start) start = (k == 4);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("done_cleared", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("rd_sel_idle", rd_sel, 32'd10);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_rd_sel"}, rd_sel, 32'd10);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_idx"}, {28'd0, class_idx}, 32'd0);
    check({tag, "_val"}, {24'd0, class_val}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{v: {8'h03, 8'h07, 8'hFE, 8'h09, 8'h01, 8'h00, 8'h04, 8'h08, 8'hFB, 8'h02}, idx: 4'd3, val: 8'h09};
    vecs[1] = '{v: {8'h9C, 8'hFD, 8'hCE, 8'hFD, 8'h80, 8'hF7, 8'hF9, 8'hEC, 8'hFC, 8'hC4}, idx: 4'd1, val: 8'hFD};
    vecs[2] = '{v: {10{8'h7F}}, idx: 4'd0, val: 8'h7F};
    vecs[3] = '{v: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F}, idx: 4'd9, val: 8'h7F};
    vecs[4] = '{v: {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h80}, idx: 4'd5, val: 8'h7F};
    vecs[5] = '{v: {10{8'h80}}, idx: 4'd0, val: 8'h80};
    vecs[6] = '{v: {8'h80, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80}, idx: 4'd1, val: 8'h7F};

    rst   = 1'b1;
    start = 1'b0;
    bank  = '0;
    repeat (2) @(negedge clk);
    check_cleared("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check_cleared("rst_release");

    // Extra start mid-scan on the first vector must not disturb timing.
    run_vec(0, 1'b1);
    for (int i = 1; i < 7; i++) run_vec(i, 1'b0);

    // Start held high: scans launch every 12 cycles.
    bank  = vecs[0].v;
    start = 1'b1;
    repeat (3) exp_q.push_back({vecs[0].idx, vecs[0].val});
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 30) start = 1'b0;
      check("b2b_done", {31'd0, done}, {31'd0, (n == 11 || n == 23 || n == 35)});
    end

    // Reset mid-scan after a known nonzero result.
    run_vec(0, 1'b0);
    bank  = vecs[1].v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_cleared("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      repeat (15) begin
        @(negedge clk);
        if (done || busy) seen = 1'b1;
      end
      check("no_done_after_rst", {31'd0, seen}, 32'd0);
    end
    run_vec(1, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
